// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data-memory port between the hart (0) and loader/debug (1).
// Optional grant/conflict statistics are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int INIT_PRIO = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req0,
    input  logic            i_req1,
    input  logic            i_wen0,
    input  logic            i_wen1,
    input  logic [AW-1:0]   i_addr0,
    input  logic [AW-1:0]   i_addr1,
    input  logic [DW-1:0]   i_wdata0,
    input  logic [DW-1:0]   i_wdata1,
    input  logic [DW/8-1:0] i_mask0,
    input  logic [DW/8-1:0] i_mask1,
    input  logic            i_lock1,
    output logic            o_gnt0,
    output logic            o_gnt1,
    output logic            o_rvalid0,
    output logic            o_rvalid1,
    output logic [DW-1:0]   o_rdata0,
    output logic [DW-1:0]   o_rdata1,
    output logic            o_mem_ren,
    output logic            o_mem_wen,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_mask,
    input  logic [DW-1:0]   i_mem_rdata,
    output logic [31:0]     o_grant_cnt0,
    output logic [31:0]     o_grant_cnt1,
    output logic [31:0]     o_conflict_cnt
);

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    localparam logic PTR_RST = (INIT_PRIO == 0) ? 1'b1 : 1'b0;

    state_t state_p0;
    logic   ptr_p0;
    logic   vld_p1;
    logic   id_p1;
    logic   arb_mode;

    // Request cycle: a LOCK cycle with i_lock1 low is arbitrated as ARB
    always_comb begin
        arb_mode = (state_p0 == ARB) || !i_lock1;
        o_gnt0   = 1'b0;
        o_gnt1   = 1'b0;
        if (arb_mode) begin
            if (i_req0 && i_req1) begin
                o_gnt0 = ptr_p0;
                o_gnt1 = !ptr_p0;
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
        end else begin
            o_gnt1 = i_req1;
        end
    end

    always_comb begin
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        if (o_gnt0) begin
            o_mem_ren   = !i_wen0;
            o_mem_wen   = i_wen0;
            o_mem_addr  = i_addr0;
            o_mem_wdata = i_wdata0;
            o_mem_mask  = i_mask0;
        end else if (o_gnt1) begin
            o_mem_ren   = !i_wen1;
            o_mem_wen   = i_wen1;
            o_mem_addr  = i_addr1;
            o_mem_wdata = i_wdata1;
            o_mem_mask  = i_mask1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0 <= ARB;
            ptr_p0   <= PTR_RST;
            vld_p1   <= 1'b0;
            id_p1    <= 1'b0;
        end else begin
            if (o_gnt0 || o_gnt1)
                ptr_p0 <= o_gnt1;
            if (o_gnt1 && i_lock1)
                state_p0 <= LOCK;
            else if (arb_mode)
                state_p0 <= ARB;
            vld_p1 <= o_mem_ren;
            if (o_mem_ren)
                id_p1 <= o_gnt1;
        end
    end

    // Response cycle: memory data passes straight through to the issuing requester
    assign o_rvalid0 = vld_p1 && !id_p1;
    assign o_rvalid1 = vld_p1 && id_p1;
    assign o_rdata0  = o_rvalid0 ? i_mem_rdata : '0;
    assign o_rdata1  = o_rvalid1 ? i_mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gcnt0_p0;
    logic [31:0] gcnt1_p0;
    logic [31:0] ccnt_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gcnt0_p0 <= '0;
            gcnt1_p0 <= '0;
            ccnt_p0  <= '0;
        end else begin
            if (o_gnt0)
                gcnt0_p0 <= gcnt0_p0 + 32'd1;
            if (o_gnt1)
                gcnt1_p0 <= gcnt1_p0 + 32'd1;
            if (i_req0 && i_req1)
                ccnt_p0 <= ccnt_p0 + 32'd1;
        end
    end

    assign o_grant_cnt0   = gcnt0_p0;
    assign o_grant_cnt1   = gcnt1_p0;
    assign o_conflict_cnt = ccnt_p0;
`else
    assign o_grant_cnt0   = '0;
    assign o_grant_cnt1   = '0;
    assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Vector-table bench for dmem_port_arbiter with a response scoreboard and a behavioural memory.
module tb_dmem_port_arbiter;

    typedef struct {
        logic        req0, req1, wen0, wen1, lock1;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        logic [3:0]  mask0, mask1;
        logic        eg0, eg1;
    } vec_t;

    typedef struct {
        logic        rv0, rv1;
        logic [31:0] d0, d1;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, req1, wen0, wen1, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  mask0, mask1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic [31:0] gcnt0, gcnt1, ccnt;

    int n_chk = 0;
    int n_pass = 0;
    rsp_t rsp_q[$];
    logic [31:0] m_g0, m_g1, m_c;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32), .INIT_PRIO(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_wen0(wen0), .i_wen1(wen1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .i_mask0(mask0), .i_mask1(mask1), .i_lock1(lock1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask), .i_mem_rdata(mem_rdata),
        .o_grant_cnt0(gcnt0), .o_grant_cnt1(gcnt1), .o_conflict_cnt(ccnt)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Synchronous-read memory: data valid the cycle after the read strobe
    always @(posedge clk)
        mem_rdata <= mem_ren ? memf(mem_addr) : 32'h0BAD0BAD;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic [3:0] m0,
                                input logic r1, input logic w1, input logic [31:0] a1,
                                input logic [31:0] d1, input logic [3:0] m1,
                                input logic lk, input logic e0, input logic e1);
        vec_t v;
        v.req0 = r0; v.wen0 = w0; v.addr0 = a0; v.wdata0 = d0; v.mask0 = m0;
        v.req1 = r1; v.wen1 = w1; v.addr1 = a1; v.wdata1 = d1; v.mask1 = m1;
        v.lock1 = lk; v.eg0 = e0; v.eg1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic check_counters();
`ifdef DMEM_ARB_STATS_EN
        check("grant_cnt0", gcnt0, m_g0);
        check("grant_cnt1", gcnt1, m_g1);
        check("conflict_cnt", ccnt, m_c);
`else
        check("grant_cnt0_off", gcnt0, 32'h0);
        check("grant_cnt1_off", gcnt1, 32'h0);
        check("conflict_cnt_off", ccnt, 32'h0);
`endif
    endtask

    task automatic drive_idle();
        req0 = 0; req1 = 0; wen0 = 0; wen1 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mask0 = 0; mask1 = 0;
    endtask

    task automatic push_none();
        rsp_t n;
        n.rv0 = 0; n.rv1 = 0; n.d0 = 0; n.d1 = 0;
        rsp_q.push_back(n);
    endtask

    task automatic run_vec(input vec_t v);
        rsp_t e, nx;
        @(negedge clk);
        req0 = v.req0; wen0 = v.wen0; addr0 = v.addr0; wdata0 = v.wdata0; mask0 = v.mask0;
        req1 = v.req1; wen1 = v.wen1; addr1 = v.addr1; wdata1 = v.wdata1; mask1 = v.mask1;
        lock1 = v.lock1;
        #1;
        if (rsp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = rsp_q.pop_front();
            check("rvalid0", {31'd0, rvalid0}, {31'd0, e.rv0});
            check("rvalid1", {31'd0, rvalid1}, {31'd0, e.rv1});
            check("rdata0", rdata0, e.d0);
            check("rdata1", rdata1, e.d1);
        end
        check("gnt0", {31'd0, gnt0}, {31'd0, v.eg0});
        check("gnt1", {31'd0, gnt1}, {31'd0, v.eg1});
        if (v.eg0) begin
            check("mem_ren", {31'd0, mem_ren}, {31'd0, !v.wen0});
            check("mem_wen", {31'd0, mem_wen}, {31'd0, v.wen0});
            check("mem_addr", mem_addr, v.addr0);
            check("mem_wdata", mem_wdata, v.wdata0);
            check("mem_mask", {28'd0, mem_mask}, {28'd0, v.mask0});
        end else if (v.eg1) begin
            check("mem_ren", {31'd0, mem_ren}, {31'd0, !v.wen1});
            check("mem_wen", {31'd0, mem_wen}, {31'd0, v.wen1});
            check("mem_addr", mem_addr, v.addr1);
            check("mem_wdata", mem_wdata, v.wdata1);
            check("mem_mask", {28'd0, mem_mask}, {28'd0, v.mask1});
        end else begin
            check("mem_idle", {mem_addr[27:0], mem_mask, mem_ren, mem_wen} , 34'd0 >> 2);
            check("mem_wdata_idle", mem_wdata, 32'h0);
        end
        check_counters();
        nx.rv0 = v.eg0 && !v.wen0;
        nx.rv1 = v.eg1 && !v.wen1;
        nx.d0  = nx.rv0 ? memf(v.addr0) : 32'h0;
        nx.d1  = nx.rv1 ? memf(v.addr1) : 32'h0;
        rsp_q.push_back(nx);
        m_g0 += {31'd0, v.eg0};
        m_g1 += {31'd0, v.eg1};
        m_c  += {31'd0, v.req0 && v.req1};
    endtask

    // Reset asserted mid-cycle right after a grant's clock edge
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        m_g0 = 0; m_g1 = 0; m_c = 0;
        check_counters();
        drive_idle();
        rsp_q.delete();
        push_none();
        @(negedge clk);
        rst_n = 1;
    endtask

    localparam int NV = 19;
    vec_t tbl [0:NV-1];
    vec_t seq [0:5];

    initial begin
        m_g0 = 0; m_g1 = 0; m_c = 0;
        drive_idle();
        // Two reads at a time alternate 0,1,0,1 from reset
        tbl[0]  = mk(1,0,32'h100,0,4'hF, 1,0,32'h200,0,4'hF, 0, 1,0);
        tbl[1]  = mk(1,0,32'h104,0,4'hF, 1,0,32'h200,0,4'hF, 0, 0,1);
        tbl[2]  = mk(1,0,32'h104,0,4'hF, 1,0,32'h204,0,4'hF, 0, 1,0);
        tbl[3]  = mk(1,0,32'h108,0,4'h7, 1,0,32'h204,0,4'hE, 0, 0,1);
        tbl[4]  = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0);
        tbl[5]  = mk(1,0,32'h10,0,4'hF, 0,0,0,0,0, 0, 1,0);
        tbl[6]  = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0);
        tbl[7]  = mk(0,0,0,0,0, 1,1,32'h20,32'h11223344,4'b0011, 0, 0,1);
        tbl[8]  = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0);
        tbl[9]  = mk(1,1,32'h30,32'hCAFEF00D,4'b1100, 0,0,0,0,0, 0, 1,0);
        // Lock burst with requester 0 waiting, including an idle locked cycle
        tbl[10] = mk(1,0,32'h50,0,4'hF, 1,0,32'h60,0,4'hF, 1, 0,1);
        tbl[11] = mk(1,0,32'h50,0,4'hF, 1,0,32'h64,0,4'hF, 1, 0,1);
        tbl[12] = mk(1,0,32'h50,0,4'hF, 0,0,0,0,0, 1, 0,0);
        tbl[13] = mk(1,0,32'h50,0,4'hF, 1,0,32'h68,0,4'hF, 1, 0,1);
        tbl[14] = mk(1,0,32'h50,0,4'hF, 0,0,0,0,0, 0, 1,0);
        tbl[15] = mk(1,0,32'h70,0,4'hF, 1,0,32'h80,0,4'hF, 1, 0,1);
        tbl[16] = mk(1,0,32'h70,0,4'hF, 1,0,32'h84,0,4'hF, 0, 1,0);
        tbl[17] = mk(0,0,0,0,0, 1,0,32'h84,0,4'hF, 0, 0,1);
        tbl[18] = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0);

        seq[0] = mk(0,0,0,0,0, 1,0,32'h90,0,4'hF, 1, 0,1);
        seq[1] = mk(1,0,32'hA0,0,4'hF, 1,0,32'hB0,0,4'hF, 0, 1,0);
        seq[2] = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0);
        seq[3] = mk(0,0,0,0,0, 1,0,32'h94,0,4'hF, 1, 0,1);
        seq[4] = mk(1,0,32'hC0,0,4'hF, 0,0,0,0,0, 1, 1,0);
        seq[5] = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("reset_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);
        check("reset_mem_ren", {31'd0, mem_ren}, 32'd0);
        check_counters();
        push_none();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < NV; i++) run_vec(tbl[i]);

        // Reset discards the pending read and restores the initial pointer
        run_vec(seq[0]);
        async_reset();
        run_vec(seq[1]);
        run_vec(seq[2]);
        // Reset abandons LOCK: locked-idle request pattern is granted to port 0
        run_vec(seq[3]);
        async_reset();
        run_vec(seq[4]);
        run_vec(seq[5]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
